// File: rtl/edram_host_port.sv
// -----------------------------------------------------------------------------
// edram_host_port
//   Bus-side initiator for the 1 Mb eDRAM array. It accepts one valid/ready
//   host request at a time and turns it into an array-pin transaction. A bank
//   that may have been power-gated gets WAKE_CYCLES of pin hold before the
//   ACCESS_CYCLES of the real access. Banks are remembered as awake until
//   IDLE_TIMEOUT consecutive idle cycles pass.
//
//   Optional feature: define EDRAM_HOST_PERF_EN to add saturating read, write
//   and wake counters with a synchronous clear input.
//
// Ports
//   clk, rst         clock, async active-high reset
//   req_valid/ready  host request handshake; req_we, req_addr, req_wdata
//                    are sampled on the accept edge only
//   rsp_valid/ready  read response handshake; rsp_rdata is held until taken
//   mem_ce_n/we_n    registered array strobes, active low
//   mem_addr/din     registered array address / write data
//   mem_dout         array read data
//   busy             high whenever the FSM is not IDLE
//   perf_*           (EDRAM_HOST_PERF_EN only) counters and their clear
// -----------------------------------------------------------------------------
module edram_host_port #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned WAKE_CYCLES   = 4,
   parameter int unsigned IDLE_TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [14:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        mem_ce_n,
   output logic        mem_we_n,
   output logic [14:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout,
   output logic        busy
`ifdef EDRAM_HOST_PERF_EN
   ,
   input  logic        perf_clr,
   output logic [15:0] perf_rd_cnt,
   output logic [15:0] perf_wr_cnt,
   output logic [15:0] perf_wake_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, WAKE, ACCESS, RESP} state_t;

   localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYCLES - 1);
   localparam logic [3:0]  ACC_LAST  = 4'(ACCESS_CYCLES - 1);
   localparam logic [15:0] TIMEOUT   = 16'(IDLE_TIMEOUT);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;      // cycles left in WAKE/ACCESS, minus one
   logic [15:0] idle_cnt;
   logic [15:0] awake;            // banks known to be powered
   logic        we_q;
   logic        accept;
   logic        last_access;
   logic        bank_awake;

   assign bank_awake  = awake[req_addr[14:11]];
   assign accept      = (state == IDLE) && req_valid;
   assign last_access = (state == ACCESS) && (cnt == 4'd0);
   assign req_ready   = (state == IDLE);
   assign rsp_valid   = (state == RESP);
   assign busy        = (state != IDLE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (bank_awake) begin
                  state_nx = ACCESS;
                  cnt_nx   = ACC_LAST;
               end else begin
                  state_nx = WAKE;
                  cnt_nx   = WAKE_LAST;
               end
            end
         end
         WAKE: begin
            if (cnt == 4'd0) begin
               state_nx = ACCESS;
               cnt_nx   = ACC_LAST;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) state_nx = we_q ? IDLE : RESP;
            else             cnt_nx   = cnt - 4'd1;
         end
         RESP: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ------------------------------------------------------- pin datapath
   // Strobes go low on the accept edge and high on the edge leaving ACCESS,
   // so WAKE and ACCESS both see the pins driven. Address/data just hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q      <= 1'b0;
         mem_ce_n  <= 1'b1;
         mem_we_n  <= 1'b1;
         mem_addr  <= '0;
         mem_din   <= '0;
         rsp_rdata <= '0;
      end else begin
         if (accept) begin
            we_q     <= req_we;
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
            mem_ce_n <= 1'b0;
            mem_we_n <= ~req_we;
         end
         if (last_access) begin
            mem_ce_n <= 1'b1;
            mem_we_n <= 1'b1;
            if (!we_q) rsp_rdata <= mem_dout;
         end
      end
   end

   // ------------------------------------------ wake tracking / idle timer
   // The counter saturates at TIMEOUT, so the mask is dropped exactly once per
   // idle period. An accept in the same cycle clears the counter instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
         awake    <= '0;
      end else begin
         if (accept) begin
            idle_cnt <= '0;
         end else if ((state == IDLE) && (idle_cnt != TIMEOUT)) begin
            idle_cnt <= idle_cnt + 16'd1;
            if ((idle_cnt + 16'd1) == TIMEOUT) awake <= '0;
         end
         if (last_access) awake[mem_addr[14:11]] <= 1'b1;
      end
   end

`ifdef EDRAM_HOST_PERF_EN
   // ------------------------------------------------ performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_rd_cnt   <= '0;
         perf_wr_cnt   <= '0;
         perf_wake_cnt <= '0;
      end else if (perf_clr) begin
         perf_rd_cnt   <= '0;
         perf_wr_cnt   <= '0;
         perf_wake_cnt <= '0;
      end else if (accept) begin
         if (!req_we && perf_rd_cnt != 16'hFFFF) perf_rd_cnt <= perf_rd_cnt + 16'd1;
         if (req_we && perf_wr_cnt != 16'hFFFF)  perf_wr_cnt <= perf_wr_cnt + 16'd1;
         if (!bank_awake && perf_wake_cnt != 16'hFFFF)
            perf_wake_cnt <= perf_wake_cnt + 16'd1;
      end
   end
`endif

endmodule
